lvt_regfile_nwmr: RTL and testbench
===================================

# lvt_regfile_nwmr

Parametrised multiported register file: NW write ports and NR read ports built from NW one-write banks, each replicated for all read ports, plus a Live Value Table (LVT) recording which bank holds the newest value of each entry. It generalises the fixed two-write/four-read memory: port counts, width and depth are parameters. It adds deterministic write-collision resolution, optional same-cycle write-to-read bypass, and a self-clearing reset sequence. It is the register file for the moxie issue stage.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 16: number of entries; power of two, at least 2. AW = clog2(DEPTH).
- NW, 2: write ports, 1..4. LVT entry width LW = max(1, clog2(NW)).
- NR, 4: read ports, 1..8.
- BYPASS, 1: 1 = a same-cycle write is forwarded to reads; 0 = reads return stored contents only.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ready  out  1  high when the clear sequence is done and writes are accepted.
- we  in  NW  per-port write enable; bit i belongs to port i.
- write_addr  in  NW*AW  port i uses bits [i*AW +: AW].
- write_data  in  NW*WIDTH  port i uses bits [i*WIDTH +: WIDTH].
- read_addr  in  NR*AW  port j uses bits [j*AW +: AW].
- read_data  out  NR*WIDTH  port j uses bits [j*WIDTH +: WIDTH]; combinational from read_addr.

## Operation
- State machine: CLEAR and RUN.
- Reset_n low at any edge puts the block in CLEAR with clr_cnt = 0 and ready = 0. This applies mid-operation too, and the clear sequence restarts.
- CLEAR, with reset_n high: each edge writes 0 to entry clr_cnt in every bank, sets LVT[clr_cnt] = 0, and increments clr_cnt. When clr_cnt = DEPTH-1 is cleared, the next state is RUN.
- RUN: ready = 1.
  - Each port i with we[i]=1 writes write_data_i to bank i at write_addr_i and sets LVT[write_addr_i] = i.
- Collision: when several enabled ports share an address, the highest-index port wins. Only that bank and the LVT entry are updated; lower-index colliding writes are dropped.
- In CLEAR, we is ignored.
- Read port j returns bank[LVT[a]][a] with a = read_addr_j.
  - In CLEAR, read_data is forced to 0.
- Bypass (BYPASS=1, RUN): if any enabled write port targets read_addr_j in the same cycle, read_data_j is that port's write_data. The highest index wins, matching the collision rule.
- LVT arithmetic: LW-bit unsigned. Bank select values NW..2^LW-1 never occur.

## Timing
- Reset values: ready = 0 and read_data = 0 while reset_n is low.
- Reset is released at edge E (first edge with reset_n high). ready rises after edge E+DEPTH-1, so it is high in the cycle following that edge (DEPTH clear cycles).
- A write at edge T is visible on read_data from just after T (zero-cycle read, one-edge write).
- With BYPASS=1, the write is also visible combinationally in the cycle before T.
- A read of an address being written, with BYPASS=0, returns the old value until the edge.
- All NW writes and NR reads complete every cycle; there is no backpressure.

## Test plan
- Reset/clear: DEPTH=16. Hold reset_n low for 3 cycles, release. Required: ready=0 for exactly 16 cycles, then 1; every read returns 0. Pulse reset_n low at clear cycle 7: clear restarts and ready is delayed a further 16 cycles from the new release.
- Independent writes: port0 writes addr3=0xAAAA0003 and port1 writes addr5=0x55550005 in one cycle. Next cycle, read ports 0..3 on addrs 3,5,3,5 return the matching values.
- Last-writer tracking: port0 writes addr2=0x11; next cycle port1 writes addr2=0x22; next cycle port0 writes addr2=0x33. After each edge, all read ports on addr2 return 0x11, then 0x22, then 0x33.
- Collision: NW=3. Ports 0, 1 and 2 write addr9 with 0xA, 0xB and 0xC. Required: addr9 reads 0xC afterward. Then port1 alone writes addr9=0xD and it reads 0xD.
- Bypass: BYPASS=1, port1 writes addr4=0xBEEF while read port 2 reads addr4. Required: 0xBEEF in the same cycle. Repeat with BYPASS=0: the old value in that cycle and 0xBEEF after the edge.
- Writes during CLEAR: assert we with data 0xFF at cycle 3 of the clear sequence. Required: no effect; all entries read 0 once ready=1.

Source files
------------

// File: rtl/lvt_regfile_nwmr.sv
// Multiported register file: NW one-write banks replicated per read port,
// with a live value table selecting the bank that holds each entry's newest value.
module lvt_regfile_nwmr #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int NW     = 2,
  parameter int NR     = 4,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                ready,
  input  logic [NW-1:0]       we,
  input  logic [NW*AW-1:0]    write_addr,
  input  logic [NW*WIDTH-1:0] write_data,
  input  logic [NR*AW-1:0]    read_addr,
  output logic [NR*WIDTH-1:0] read_data
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_reg;
  logic [AW-1:0]   clr_cnt_reg;
  logic            ready_reg;
  logic            run;
  logic            clearing;
  logic [NW-1:0]   wr_en;
  logic [LW-1:0]   lvt [DEPTH];
  logic [WIDTH-1:0] bank_rd [NR][NW];

  assign run      = (state_reg == RUN);
  assign clearing = (state_reg == CLEAR) && reset_n;
  assign ready    = ready_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == AW'(DEPTH - 1)) begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
          end
        end
        default: ready_reg <= 1'b1;
      endcase
    end
  end

  // A port is dropped when any higher-index enabled port targets the same address.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NW; i++) begin
      wr_en[i] = we[i] && run;
      for (int k = i + 1; k < NW; k++) begin
        if (we[k] && (write_addr[k*AW +: AW] == write_addr[i*AW +: AW]))
          wr_en[i] = 1'b0;
      end
    end
  end

  // Winning writes have distinct addresses, so loop order does not matter here.
  always_ff @(posedge clock) begin
    if (clearing) begin
      lvt[clr_cnt_reg] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (wr_en[i])
          lvt[write_addr[i*AW +: AW]] <= LW'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NW; gi++) begin : g_bank
    for (genvar gj = 0; gj < NR; gj++) begin : g_rep
      logic [WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clock) begin
        if (clearing)
          mem[clr_cnt_reg] <= '0;
        else if (wr_en[gi])
          mem[write_addr[gi*AW +: AW]] <= write_data[gi*WIDTH +: WIDTH];
      end

      assign bank_rd[gj][gi] = mem[read_addr[gj*AW +: AW]];
    end
  end

  always_comb begin
    read_data = '0;
    for (int j = 0; j < NR; j++) begin
      logic [LW-1:0]    sel;
      logic [WIDTH-1:0] word;
      sel  = lvt[read_addr[j*AW +: AW]];
      word = '0;
      for (int i = 0; i < NW; i++) begin
        if (sel == LW'(i))
          word = bank_rd[j][i];
      end
      if (BYPASS != 0) begin
        for (int i = 0; i < NW; i++) begin
          if (we[i] && (write_addr[i*AW +: AW] == read_addr[j*AW +: AW]))
            word = write_data[i*WIDTH +: WIDTH];
        end
      end
      if (!run)
        word = '0;
      read_data[j*WIDTH +: WIDTH] = word;
    end
  end

endmodule

// File: tb/tb_lvt_regfile_nwmr.sv
// Scoreboard bench: a bypassing and a non-bypassing instance share stimulus and
// are checked against a single logical memory model.
module tb_lvt_regfile_nwmr;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int NW    = 3;
  localparam int NR    = 4;
  localparam int AW    = $clog2(DEPTH);

  logic                clk;
  logic                reset_n;
  logic [NW-1:0]       we;
  logic [NW*AW-1:0]    wa;
  logic [NW*WIDTH-1:0] wd;
  logic [NR*AW-1:0]    ra;
  logic                ready_b, ready_n;
  logic [NR*WIDTH-1:0] rd_b, rd_n;

  lvt_regfile_nwmr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NW(NW), .NR(NR), .BYPASS(1)) dut_b (
    .clock(clk), .reset_n(reset_n), .ready(ready_b), .we(we), .write_addr(wa),
    .write_data(wd), .read_addr(ra), .read_data(rd_b));

  lvt_regfile_nwmr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NW(NW), .NR(NR), .BYPASS(0)) dut_n (
    .clock(clk), .reset_n(reset_n), .ready(ready_n), .we(we), .write_addr(wa),
    .write_data(wd), .read_addr(ra), .read_data(rd_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: one logical memory holding the newest value per address.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_ready;
  int               m_cnt;

  typedef struct {
    logic                rdy;
    logic [NR*WIDTH-1:0] exp_b;
    logic [NR*WIDTH-1:0] exp_n;
  } exp_t;
  exp_t sb_q[$];

  function automatic exp_t predict();
    exp_t e;
    e.rdy = m_ready;
    for (int j = 0; j < NR; j++) begin
      int a;
      logic [WIDTH-1:0] v, vb;
      a  = int'(ra[j*AW +: AW]);
      v  = m_ready ? m_mem[a] : '0;
      vb = v;
      if (m_ready)
        for (int i = 0; i < NW; i++)
          if (we[i] && int'(wa[i*AW +: AW]) == a) vb = wd[i*WIDTH +: WIDTH];
      e.exp_n[j*WIDTH +: WIDTH] = v;
      e.exp_b[j*WIDTH +: WIDTH] = vb;
    end
    return e;
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
    end else begin
      for (int i = 0; i < NW; i++)
        if (we[i]) m_mem[int'(wa[i*AW +: AW])] = wd[i*WIDTH +: WIDTH];
    end
  endtask

  task automatic step();
    sb_q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic setw(input int p, input int a, input logic [WIDTH-1:0] d);
    wa[p*AW +: AW]       = AW'(a);
    wd[p*WIDTH +: WIDTH] = d;
  endtask

  task automatic set_all_ra(input int a);
    for (int j = 0; j < NR; j++) ra[j*AW +: AW] = AW'(a);
  endtask

  task automatic rand_inputs(input bit allow_we);
    for (int i = 0; i < NW; i++)
      setw(i, ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1),
           WIDTH'($urandom));
    for (int j = 0; j < NR; j++)
      ra[j*AW +: AW] = AW'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 3)
                                                         : $urandom_range(0, DEPTH - 1));
    we = allow_we ? NW'($urandom) : '0;
  endtask

  // Monitor: outputs are combinational and always presented; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (ready_b !== e.rdy || ready_n !== e.rdy) begin
          failures++;
          $display("FAIL ready: got b=%0b n=%0b want %0b", ready_b, ready_n, e.rdy);
        end
        for (int j = 0; j < NR; j++) begin
          checks++;
          if (rd_b[j*WIDTH +: WIDTH] !== e.exp_b[j*WIDTH +: WIDTH]) begin
            failures++;
            $display("FAIL read_bypass port%0d addr=%0d: got %h want %h", j,
                     ra[j*AW +: AW], rd_b[j*WIDTH +: WIDTH], e.exp_b[j*WIDTH +: WIDTH]);
          end
          checks++;
          if (rd_n[j*WIDTH +: WIDTH] !== e.exp_n[j*WIDTH +: WIDTH]) begin
            failures++;
            $display("FAIL read_nobypass port%0d addr=%0d: got %h want %h", j,
                     ra[j*AW +: AW], rd_n[j*WIDTH +: WIDTH], e.exp_n[j*WIDTH +: WIDTH]);
          end
        end
      end
    end
  end

  initial begin
    int ready_len;
    reset_n = 1'b0;
    we = '0; wa = '0; wd = '0; ra = '0;
    m_ready = 1'b0;
    m_cnt = 0;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    @(posedge clk); #1;

    repeat (3) step();
    reset_n = 1'b1;

    // First clear attempt; writes at clear cycle 3 must be ignored, reset at cycle 7.
    for (int c = 0; c < 7; c++) begin
      rand_inputs(1'b0);
      if (c == 3) begin
        we = '1;
        for (int i = 0; i < NW; i++) setw(i, i + 1, 32'hFF);
      end
      step();
    end
    we = '0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;

    ready_len = 0;
    for (int k = 1; k <= 40 && ready_len == 0; k++) begin
      rand_inputs(1'b0);
      if (k == 3) begin
        we = '1;
        for (int i = 0; i < NW; i++) setw(i, i * 5, 32'hFF);
      end
      step();
      if (ready_b) ready_len = k;
    end
    checks++;
    if (ready_len != DEPTH) begin
      failures++;
      $display("FAIL clear_length: got %0d cycles want %0d", ready_len, DEPTH);
    end
    $display("clear done after %0d cycles", ready_len);

    we = '0;
    for (int a = 0; a < DEPTH; a += NR) begin
      for (int j = 0; j < NR; j++) ra[j*AW +: AW] = AW'(a + j);
      step();
    end

    // Independent writes on two ports.
    setw(0, 3, 32'hAAAA0003);
    setw(1, 5, 32'h55550005);
    we = 3'b011;
    ra = {AW'(5), AW'(3), AW'(5), AW'(3)};
    step();
    we = '0;
    step();

    // Last-writer tracking across ports on addr 2.
    set_all_ra(2);
    setw(0, 2, 32'h11); we = 3'b001; step(); we = '0; step();
    setw(1, 2, 32'h22); we = 3'b010; step(); we = '0; step();
    setw(0, 2, 32'h33); we = 3'b001; step(); we = '0; step();

    // Three-way collision, then a lone lower-index write.
    set_all_ra(9);
    setw(0, 9, 32'hA); setw(1, 9, 32'hB); setw(2, 9, 32'hC);
    we = 3'b111; step(); we = '0; step();
    setw(1, 9, 32'hD); we = 3'b010; step(); we = '0; step();

    // Same-cycle write/read of addr 4.
    setw(1, 4, 32'hBEEF);
    ra = {AW'(0), AW'(4), AW'(9), AW'(2)};
    we = 3'b010; step(); we = '0; step();

    for (int n = 0; n < 400; n++) begin
      rand_inputs(1'b1);
      step();
    end

    // Mid-operation reset, then more random traffic.
    we = '0;
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int n = 0; n < DEPTH + 40; n++) begin
      rand_inputs(1'b1);
      step();
    end

    we = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
